// File: rtl/match_scoreboard.sv
// Best-of-N match scoreboard: counts finished games from game_over/who and
// hands out one result record per match. Optional streak tracking: MATCH_STREAK_EN.
module match_scoreboard #(
    parameter int GAMES_PER_MATCH = 5,
    parameter int SCORE_W         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   winner,
    input  logic                   loser,
    input  logic                   game_over,
    input  logic [1:0]             who,
    output logic [SCORE_W-1:0]     games_won,
    output logic [SCORE_W-1:0]     games_lost,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2+2*SCORE_W-1:0] res_data,
    output logic                   illegal_who,
    output logic                   overrun,
    output logic [SCORE_W-1:0]     max_streak
);
    localparam int NEED = (GAMES_PER_MATCH + 1) / 2;
    localparam logic [SCORE_W-1:0] NEED_V    = SCORE_W'(NEED);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {IDLE, PLAY, REPORT} state_t;
    state_t state;

    logic game_over_d;
    logic go_rise;
    logic [SCORE_W-1:0] won_inc;
    logic [SCORE_W-1:0] lost_inc;

    assign go_rise  = game_over & ~game_over_d;
    assign won_inc  = (games_won == SCORE_MAX) ? games_won : games_won + SCORE_W'(1);
    assign lost_inc = (games_lost == SCORE_MAX) ? games_lost : games_lost + SCORE_W'(1);

    // Handshake: res_valid is registered and rises only on the deciding game;
    // res_data is frozen until the edge where res_valid and res_ready are both high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            game_over_d <= 1'b0;
            games_won   <= '0;
            games_lost  <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            illegal_who <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            game_over_d <= game_over;
            case (state)
                IDLE: begin
                    if (start) begin
                        games_won   <= '0;
                        games_lost  <= '0;
                        illegal_who <= 1'b0;
                        overrun     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= PLAY;
                    end
                end
                PLAY: begin
                    if (go_rise) begin
                        case (who)
                            2'b10: begin
                                games_won <= won_inc;
                                if (won_inc == NEED_V) begin
                                    state     <= REPORT;
                                    res_valid <= 1'b1;
                                    res_data  <= {2'b10, won_inc, games_lost};
                                end
                            end
                            2'b01: begin
                                games_lost <= lost_inc;
                                if (lost_inc == NEED_V) begin
                                    state     <= REPORT;
                                    res_valid <= 1'b1;
                                    res_data  <= {2'b01, games_won, lost_inc};
                                end
                            end
                            default: illegal_who <= 1'b1;
                        endcase
                    end
                end
                REPORT: begin
                    if (go_rise) overrun <= 1'b1;
                    if (res_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MATCH_STREAK_EN
    logic winner_d;
    logic loser_d;
    logic [SCORE_W-1:0] streak;
    logic [SCORE_W-1:0] streak_inc;

    assign streak_inc = (streak == SCORE_MAX) ? streak : streak + SCORE_W'(1);

    // A loser edge beats a simultaneous winner edge; the streak survives game ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_d   <= 1'b0;
            loser_d    <= 1'b0;
            streak     <= '0;
            max_streak <= '0;
        end else begin
            winner_d <= winner;
            loser_d  <= loser;
            if (state == IDLE && start) begin
                streak     <= '0;
                max_streak <= '0;
            end else if (loser && !loser_d) begin
                streak <= '0;
            end else if (state == PLAY && winner && !winner_d) begin
                streak <= streak_inc;
                if (streak_inc > max_streak) max_streak <= streak_inc;
            end
        end
    end
`else
    logic unused_streak_inputs;
    assign unused_streak_inputs = winner ^ loser;
    assign max_streak = '0;
`endif

endmodule

// File: tb/tb_match_scoreboard.sv
// Randomized and directed bench for match_scoreboard (best-of-3, 4-bit scores)
// against an event-level reference model and a record scoreboard.
module tb_match_scoreboard;
    localparam int GPM  = 3;
    localparam int SW   = 4;
    localparam int NEED = (GPM + 1) / 2;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic winner = 1'b0;
    logic loser = 1'b0;
    logic game_over = 1'b0;
    logic [1:0] who = 2'b00;
    logic res_ready = 1'b0;
    logic [SW-1:0] games_won;
    logic [SW-1:0] games_lost;
    logic busy;
    logic res_valid;
    logic [2+2*SW-1:0] res_data;
    logic illegal_who;
    logic overrun;
    logic [SW-1:0] max_streak;

    match_scoreboard #(.GAMES_PER_MATCH(GPM), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .winner(winner), .loser(loser),
        .game_over(game_over), .who(who), .games_won(games_won),
        .games_lost(games_lost), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .illegal_who(illegal_who),
        .overrun(overrun), .max_streak(max_streak)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: match phase 0=idle 1=playing 2=result pending
    int m_mode, m_won, m_lost, m_ill, m_ovr, m_streak, m_max, m_rec;
    int m_go_prev, m_w_prev, m_l_prev;
    logic [2+2*SW-1:0] exp_q[$];
    logic [2+2*SW-1:0] pre_data;

    task automatic model_reset();
        m_mode = 0; m_won = 0; m_lost = 0; m_ill = 0; m_ovr = 0;
        m_streak = 0; m_max = 0; m_rec = 0;
        m_go_prev = 0; m_w_prev = 0; m_l_prev = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int game_end;
        logic [2+2*SW-1:0] got;
        game_end = (game_over && m_go_prev == 0) ? 1 : 0;
`ifdef MATCH_STREAK_EN
        if (m_mode == 0 && start) begin
            m_streak = 0; m_max = 0;
        end else if (loser && m_l_prev == 0) begin
            m_streak = 0;
        end else if (m_mode == 1 && winner && m_w_prev == 0) begin
            if (m_streak < SMAX) m_streak++;
            if (m_streak > m_max) m_max = m_streak;
        end
`endif
        case (m_mode)
            0: if (start) begin
                m_won = 0; m_lost = 0; m_ill = 0; m_ovr = 0; m_mode = 1;
            end
            1: if (game_end) begin
                if (who == 2'b10) begin
                    if (m_won < SMAX) m_won++;
                    if (m_won == NEED) begin
                        m_mode = 2; m_rec = (2 << (2*SW)) | (m_won << SW) | m_lost;
                        exp_q.push_back(m_rec[2+2*SW-1:0]);
                    end
                end else if (who == 2'b01) begin
                    if (m_lost < SMAX) m_lost++;
                    if (m_lost == NEED) begin
                        m_mode = 2; m_rec = (1 << (2*SW)) | (m_won << SW) | m_lost;
                        exp_q.push_back(m_rec[2+2*SW-1:0]);
                    end
                end else begin
                    m_ill = 1;
                end
            end
            default: begin
                if (game_end) m_ovr = 1;
                if (res_ready) begin
                    m_mode = 0;
                    got = pre_data;
                    if (exp_q.size() == 0) check_eq("xfer_unexpected", 1, 0);
                    else check_eq("xfer_record", got, exp_q.pop_front());
                end
            end
        endcase
        m_go_prev = game_over ? 1 : 0;
        m_w_prev  = winner ? 1 : 0;
        m_l_prev  = loser ? 1 : 0;
    endtask

    task automatic check_all();
        check_eq("games_won", games_won, m_won);
        check_eq("games_lost", games_lost, m_lost);
        check_eq("busy", busy, (m_mode != 0) ? 1 : 0);
        check_eq("res_valid", res_valid, (m_mode == 2) ? 1 : 0);
        if (m_mode == 2) check_eq("res_data", res_data, m_rec);
        check_eq("illegal_who", illegal_who, m_ill);
        check_eq("overrun", overrun, m_ovr);
        check_eq("max_streak", max_streak, m_max);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        pre_data = res_data;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic game(input logic [1:0] w);
        game_over = 1'b1; who = w; cycle();
        game_over = 1'b0; who = 2'b00; cycle();
    endtask

    task automatic pulse_winner();
        winner = 1'b1; cycle(); winner = 1'b0; cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        check_eq("rst_res_data", res_data, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        check_eq("por_res_data", res_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Straight match win with consumer always ready
        res_ready = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        check_eq("t1_busy", busy, 1);
        game(2'b10);
        game_over = 1'b1; who = 2'b10; cycle();
        check_eq("t1_valid", res_valid, 1);
        check_eq("t1_data", res_data, 10'b10_0010_0000);
        game_over = 1'b0; who = 2'b00; cycle();
        check_eq("t1_idle", busy, 0);

        // Split match lost, with backpressure
        res_ready = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        game(2'b10); game(2'b01); game(2'b01);
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_hold", res_data, 10'b01_0001_0010);
            cycle();
        end
        res_ready = 1'b1; cycle(); res_ready = 1'b0;
        check_eq("t2_done_valid", res_valid, 0);
        check_eq("t2_queue_empty", exp_q.size(), 0);

        // Illegal outcome, then a long game_over pulse
        start = 1'b1; cycle(); start = 1'b0;
        game(2'b00);
        check_eq("t3_illegal", illegal_who, 1);
        game_over = 1'b1; who = 2'b10;
        for (int i = 0; i < 3; i++) cycle();
        game_over = 1'b0; who = 2'b00; cycle();
        check_eq("t3_won_once", games_won, 1);

        // Overrun in REPORT, then an ignored game in IDLE
        game(2'b10);
        check_eq("t4_report", res_valid, 1);
        game(2'b01);
        check_eq("t4_overrun", overrun, 1);
        check_eq("t4_lost_unchanged", games_lost, 0);
        res_ready = 1'b1; cycle(); res_ready = 1'b0;
        game(2'b10);
        check_eq("t4_idle_won", games_won, 2);
        check_eq("t4_idle_busy", busy, 0);

        // Reset mid-REPORT, then a streak
        start = 1'b1; cycle(); start = 1'b0;
        game(2'b10); game(2'b10);
        check_eq("t5_pending", res_valid, 1);
        do_reset();
        start = 1'b1; cycle(); start = 1'b0;
        pulse_winner(); pulse_winner(); pulse_winner();
        loser = 1'b1; cycle(); loser = 1'b0; cycle();
        pulse_winner();
`ifdef MATCH_STREAK_EN
        check_eq("t5_max_streak", max_streak, 3);
`else
        check_eq("t5_max_streak", max_streak, 0);
`endif

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int pick;
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) game_over = ~game_over;
            pick = $urandom_range(0, 9);
            who = (pick < 4) ? 2'b10 : (pick < 8) ? 2'b01 : (pick == 8) ? 2'b00 : 2'b11;
            winner = $urandom_range(0, 1);
            loser = ($urandom_range(0, 4) == 0);
            res_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end
        check_eq("end_queue", exp_q.size(), (m_mode == 2) ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/match_scoreboard.md
# match_scoreboard

Downstream consumer of the multi-mode counter's game status outputs. It edge-detects `game_over`, classifies each finished game from `who`, and accumulates player wins and losses over a best-of-N match. When the match is decided, it presents one result record on a valid/ready handshake. It also flags illegal game outcomes and games that arrive while a result is pending.

## Interface
- `GAMES_PER_MATCH`, default 5: best-of-N match length. Must be odd and ≥1. Games needed to decide the match: NEED = (GAMES_PER_MATCH+1)/2.
- `SCORE_W`, default 4: width of the win and loss counters. Must satisfy 2^SCORE_W > NEED.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: begin a new match. Honoured only in IDLE.
- `winner` in 1: upstream per-cycle hit flag (counter at all-ones).
- `loser` in 1: upstream per-cycle miss flag (counter at zero).
- `game_over` in 1: upstream game-end level, high for ≥1 cycle.
- `who` in 2: upstream outcome. 2'b10 means the player won the game; 2'b01 means the player lost.
- `games_won` out SCORE_W: player games won in the current or last match.
- `games_lost` out SCORE_W: player games lost in the current or last match.
- `busy` out 1: high in PLAY or REPORT.
- `res_valid` out 1: result record available.
- `res_ready` in 1: consumer accepts the record.
- `res_data` out 2+2·SCORE_W: {match_result[1:0], games_won, games_lost}. match_result is 2'b10 for a match win and 2'b01 for a match loss.
- `illegal_who` out 1: sticky; a game ended with `who` ∈ {00, 11}.
- `overrun` out 1: sticky; a game ended while in REPORT.
- `max_streak` out SCORE_W: longest run of winner hits (see Configuration).

## Operation
- States: IDLE, PLAY, REPORT.
- A game-end event, `go_rise`, is `game_over` high with `game_over_d` low. `game_over_d` is a one-cycle-delayed register of `game_over`.
- IDLE:
  - `start`=1 clears `games_won`, `games_lost`, `max_streak` and the streak counter, then moves to PLAY.
  - `go_rise` is ignored.
- PLAY, on `go_rise`:
  - `who`=10 increments `games_won`.
  - `who`=01 increments `games_lost`.
  - Any other value of `who` sets `illegal_who` and leaves the scores unchanged.
  - If the incremented score equals NEED, the state moves to REPORT. `res_data` is captured from the updated scores, with match_result taken from the score that reached NEED.
  - `start` is ignored in PLAY.
- REPORT:
  - `res_valid`=1.
  - `res_data` is held stable while `res_valid`=1 and `res_ready`=0.
  - A transfer occurs on the edge where `res_valid`=1 and `res_ready`=1. The state then moves to IDLE.
  - `go_rise` in REPORT sets `overrun`. The game is dropped and the scores are unchanged.
  - `start` is ignored in REPORT.
- Sticky flags are cleared only by `rst` or by `start` accepted in IDLE.
- Scores saturate at 2^SCORE_W−1. In practice they never exceed NEED.
- `winner` and `loser` are used only by the streak logic.

## Timing
- Reset values:
  - state IDLE.
  - `games_won`, `games_lost`, `max_streak`, `res_data` = 0.
  - `busy`, `res_valid`, `illegal_who`, `overrun` = 0.
  - `game_over_d` = 0.
- `start` sampled at edge k: `busy`=1 from cycle k+1. A `go_rise` at edge k+1 is counted.
- `go_rise` sampled at edge k: the updated score is visible at cycle k+1.
- Deciding `go_rise` at edge k: `res_valid`=1 and the record are visible at cycle k+1.
- Transfer at edge k: `res_valid`=0 and `busy`=0 at cycle k+1. A `start` sampled at edge k+1 is accepted.
- Combinational paths: `res_ready` never reaches `res_valid` combinationally, and all outputs are registered.
- `game_over` held high for multiple cycles counts once. A new game needs `game_over` to fall before it can be counted again.
- `rst` asserted mid-match or mid-REPORT takes effect immediately. Any pending record is lost.

## Configuration
- `MATCH_STREAK_EN` defined:
  - A streak counter counts `winner` rising edges in PLAY and clears on each `loser` rising edge.
  - `max_streak` holds the maximum streak value reached, saturating at 2^SCORE_W−1.
  - The streak counter does not reset at `go_rise`.
- `MATCH_STREAK_EN` undefined:
  - The streak logic is removed and `max_streak` is tied to 0.

## Test plan
- Bench uses GAMES_PER_MATCH=3, SCORE_W=4, so NEED=2.
- Basic match win: `start`, then two `go_rise` with `who`=10.
  - `res_valid`=1 one cycle after the second event.
  - `res_data`={10, 2, 0}.
  - With `res_ready`=1, `busy`=0 the next cycle.
- Split match lost, with backpressure: events `who`=10, 01, 01, and `res_ready` held 0 for 5 cycles.
  - `res_data`={01, 1, 2}, stable all 5 cycles.
  - A single transfer, then IDLE.
- Illegal outcome and a long `game_over` pulse: event with `who`=00, then `game_over` high for 3 cycles with `who`=10.
  - `illegal_who`=1.
  - `games_won`=1, not 3.
- Overrun, and events outside PLAY: a `go_rise` in REPORT, and a `go_rise` in IDLE.
  - REPORT event: `overrun`=1, scores unchanged.
  - IDLE event: no flag and no score change.
- Reset and streak: `rst` pulsed mid-REPORT, then a new `start`.
  - After reset, all outputs are 0.
  - With `MATCH_STREAK_EN`: `winner` pulses ×3, a `loser` pulse, then `winner` ×1 gives `max_streak`=3.
  - Without `MATCH_STREAK_EN`: `max_streak`=0 throughout.
